// File: rtl/can_rec_arbiter_if.sv
// Bus between the CAN receive arbiter and its requesters / uplink read path.
interface can_rec_arbiter_if #(
    parameter int N_BUS = 16
);
    logic [4:0]       n_buses;
    logic [N_BUS-1:0] irq_can_rec;
    logic             read_ack;
    logic             endwait_all;
    logic [4:0]       can_rec_select;
    logic             read_req;
    logic             busy;
    logic             timeout_err;
    logic [4:0]       timeout_bus;

    modport slave (
        input  n_buses, irq_can_rec, read_ack, endwait_all,
        output can_rec_select, read_req, busy, timeout_err, timeout_bus
    );

    modport master (
        output n_buses, irq_can_rec, read_ack, endwait_all,
        input  can_rec_select, read_req, busy, timeout_err, timeout_bus
    );
endinterface

// File: rtl/can_rec_arbiter.sv
// Round-robin arbiter granting one CAN receive controller at a time to the
// uplink read path, with an ack timeout and an external abort.
//
// state      | meaning
// IDLE       | searching for an eligible requester
// GRANT      | one cycle, read_req asserted for can_rec_select
// WAIT_ACK   | waiting for read_ack, counting toward TIMEOUT
// RELEASE    | one idle cycle so the controller can drop its irq
module can_rec_arbiter #(
    parameter int N_BUS   = 16,
    parameter int TIMEOUT = 1023
) (
    input logic              clk,
    input logic              rst,
    can_rec_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_ACK,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    sel_q, sel_d;
    logic [4:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_err_q, tmo_err_d;
    logic [4:0]    tmo_bus_q, tmo_bus_d;

    logic          win_found;
    logic [4:0]    win_idx;
    logic          tmo_hit;

    // Round-robin search from ptr+1; scanning far-to-near lets the nearest hit win.
    always_comb begin : win_search
        int lim;
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        lim       = (int'(bus.n_buses) < N_BUS) ? int'(bus.n_buses) : N_BUS;
        for (int k = N_BUS; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N_BUS;
            if (idx < lim && bus.irq_can_rec[idx]) begin
                win_found = 1'b1;
                win_idx   = 5'(idx);
            end
        end
    end

    // The counter reaches TIMEOUT on the edge that closes this WAIT_ACK cycle.
    assign tmo_hit = (int'(cnt_q) + 1) >= TIMEOUT;

    // Next-state and register updates for the grant sequence.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tmo_err_d = 1'b0;
        tmo_bus_d = tmo_bus_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                ptr_d   = sel_q;
                cnt_d   = '0;
                state_d = bus.endwait_all ? S_RELEASE : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (bus.endwait_all || bus.read_ack) begin
                    ptr_d   = sel_q;
                    state_d = S_RELEASE;
                end else if (tmo_hit) begin
                    ptr_d     = sel_q;
                    tmo_err_d = 1'b1;
                    tmo_bus_d = sel_q;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; ptr starts at N_BUS-1 so bus 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            ptr_q     <= 5'(N_BUS - 1);
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
            tmo_bus_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
            tmo_bus_q <= tmo_bus_d;
        end
    end

    assign bus.can_rec_select = sel_q;
    assign bus.read_req       = (state_q == S_GRANT);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.timeout_err    = tmo_err_q;
    assign bus.timeout_bus    = tmo_bus_q;
endmodule

// File: doc/can_rec_arbiter.md
CAN_REC_ARBITER -- requirements
Module: can_rec_arbiter

Interface
REQ-001 SHALL have parameter N_BUS, default 16, meaning number of CAN receive requesters (bus indices 0..N_BUS-1).
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning maximum clk cycles to wait for read_ack after a grant.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port n_buses, input, 5, count of active buses; only indices < n_buses are eligible.
REQ-006 SHALL have port irq_can_rec, input, N_BUS, level request per bus (frame waiting in that CAN controller).
REQ-007 SHALL have port read_ack, input, 1, one-cycle pulse from uplink path: granted frame consumed.
REQ-008 SHALL have port endwait_all, input, 1, abort of the current grant.
REQ-009 SHALL have port can_rec_select, output, 5, index of the granted bus, registered.
REQ-010 SHALL have port read_req, output, 1, one-cycle pulse starting the uplink read of can_rec_select.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port timeout_err, output, 1, one-cycle pulse on grant timeout.
REQ-013 SHALL have port timeout_bus, output, 5, index of the last bus that timed out, held until next timeout.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, WAIT_ACK, RELEASE.
REQ-015 Eligibility SHALL be: irq_can_rec[i]=1 and i < min(n_buses, N_BUS); n_buses=0 means no bus eligible.
REQ-016 n_buses SHALL be sampled only in IDLE; changes during a grant do not affect it.
REQ-017 Winner SHALL be the first eligible index searching upward from ptr+1, wrapping modulo N_BUS (round robin).
REQ-018 IDLE: if a winner exists at an edge -> can_rec_select <= winner, state <= GRANT; otherwise stay IDLE.
REQ-019 GRANT SHALL last exactly one cycle with read_req=1; then WAIT_ACK with wait counter cleared to 0.
REQ-020 read_req SHALL be high only while in GRANT: request-to-read_req latency is 1 cycle after the sampling edge.
REQ-021 WAIT_ACK: the counter SHALL increment each cycle; read_ack=1 -> RELEASE.
REQ-022 WAIT_ACK: the counter reaching TIMEOUT without read_ack -> timeout_err=1 for one cycle, timeout_bus <= can_rec_select, then RELEASE.
REQ-023 read_ack and timeout in the same cycle SHALL count as ack; no timeout_err.
REQ-024 endwait_all=1 in GRANT or WAIT_ACK SHALL go to RELEASE next edge with no timeout_err; it is ignored in IDLE and RELEASE.
REQ-025 endwait_all SHALL take priority over read_ack and timeout in the same cycle.
REQ-026 On every exit from GRANT or WAIT_ACK, ptr SHALL be set to can_rec_select, so an aborted bus is not re-granted first.
REQ-027 RELEASE SHALL last one cycle and then return to IDLE, giving the CAN controller time to drop its irq.
REQ-028 read_ack outside WAIT_ACK SHALL be ignored.
REQ-029 A request deasserting during GRANT or WAIT_ACK SHALL not shorten the grant.
REQ-030 can_rec_select SHALL be stable from GRANT entry through RELEASE.
REQ-031 The counter width SHALL be clog2(TIMEOUT+1) and SHALL not wrap.

Reset
REQ-032 rst=1 at an edge SHALL force state IDLE, can_rec_select=0, read_req=0, busy=0, timeout_err=0, timeout_bus=0, counter=0, ptr=N_BUS-1 (first search starts at bus 0).
REQ-033 rst mid-grant SHALL abandon the grant immediately with no read_req, timeout_err or ptr update afterward.

Verification
REQ-034 n_buses=3, irq_can_rec=16'h0007 held, read_ack 4 cycles after each read_req -> grants in order 0,1,2,0; read_req pulses 1 cycle each; no timeout_err.
REQ-035 n_buses=2, irq_can_rec=16'h0004 -> busy stays 0 and no read_req (bus 2 ineligible).
REQ-036 TIMEOUT=1023, single request on bus 5, no read_ack -> timeout_err pulses exactly 1023 cycles after WAIT_ACK entry; timeout_bus=5; returns to IDLE; bus 5 is re-granted if its request is still high.
REQ-037 read_ack and timeout in the same cycle -> RELEASE with no timeout_err; endwait_all together with read_ack -> abort path, ptr still advances.
REQ-038 rst asserted in WAIT_ACK -> next cycle all outputs 0, state IDLE; with irq_can_rec=16'hFFFF and n_buses=16 the first grant after reset is bus 0.
REQ-039 n_buses changed 16->1 during WAIT_ACK on bus 9 -> grant on bus 9 completes normally; afterwards only bus 0 is granted.
